rs15_13_gf16_decoder: RTL and testbench

- Symbol-serial Reed-Solomon RS(15,13) decoder over GF(2^4), primitive polynomial x^4+x+1, generator roots alpha^1 and alpha^2.
- Receive-side counterpart of the lpGBT-FE RS encoder datapath; GF additions are bitwise XOR.
- Collects one 15-symbol codeword, computes two syndromes, then locates and corrects a single symbol error.
- Emits the 13 data symbols and updates error statistics.

---
 rtl/rs_gf16_pkg.sv | 27 ++
 rtl/rs15_13_syndrome.sv | 25 ++
 rtl/rs15_13_gf16_decoder.sv | 93 +++++++++
 tb/tb_rs15_13_gf16_decoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf16_pkg.sv
// rs_gf16_pkg: GF(2^4) tables, arithmetic and shared types for the RS(15,13) decoder
package rs_gf16_pkg;
    localparam logic [4:0] PRIM_POLY = 5'b10011;
    localparam int N = 15;
    localparam int K = 13;
    // entry 15 wraps to alpha^15 = 1 so a 4-bit index is always in range
    localparam logic [3:0] GF_EXP [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                          4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    localparam logic [3:0] GF_LOG [16] = '{4'd0, 4'd0, 4'd1, 4'd4, 4'd2, 4'd8, 4'd5, 4'd10,
                                          4'd3, 4'd14, 4'd9, 4'd7, 4'd6, 4'd13, 4'd11, 4'd12};
    localparam logic [3:0] GF_INV [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                                          4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

    typedef enum logic [1:0] {IDLE, COLLECT, CALC, OUTPUT} state_t;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] t;
        acc = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ t;
            t = t[3] ? ({t[2:0], 1'b0} ^ PRIM_POLY[3:0]) : {t[2:0], 1'b0};
        end
        return acc;
    endfunction
endpackage

// File: rtl/rs15_13_syndrome.sv
// rs15_13_syndrome: Horner accumulators evaluating the received word at alpha and alpha^2
module rs15_13_syndrome
    import rs_gf16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] sym,
    output logic [3:0] s1,
    output logic [3:0] s2
);
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 4'h0;
            s2 <= 4'h0;
        end else if (en) begin
            s1 <= gf_mul(clr ? 4'h0 : s1, GF_EXP[1]) ^ sym;
            s2 <= gf_mul(clr ? 4'h0 : s2, GF_EXP[2]) ^ sym;
        end else if (clr) begin
            s1 <= 4'h0;
            s2 <= 4'h0;
        end
    end
endmodule

// File: rtl/rs15_13_gf16_decoder.sv
// rs15_13_gf16_decoder: symbol-serial RS(15,13) single-error decoder over GF(2^4)
module rs15_13_gf16_decoder
    import rs_gf16_pkg::*;
#(
    parameter bit CORRECT_EN = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_sym,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_sym,
    output logic             out_valid,
    output logic             out_last,
    output logic             cw_done,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    state_t state, state_nx;
    logic [3:0] idx, s1, s2, fix_e, fix_p, calc_x;
    logic [3:0] sym_buf [N];
    logic corr_q, uncorr_q, accept, fix_hit;

    assign in_ready  = state == IDLE || state == COLLECT;
    assign accept    = in_valid && in_ready;
    assign out_valid = state == OUTPUT;
    assign out_last  = out_valid && idx == 4'(K - 1);
    assign cw_done   = out_last;
    assign fix_hit   = CORRECT_EN && corr_q && idx == fix_p;
    assign out_sym   = out_valid ? sym_buf[idx] ^ (fix_hit ? fix_e : 4'h0) : 4'h0;
    assign calc_x    = gf_mul(s2, GF_INV[s1]);

    rs15_13_syndrome u_syn (
        .clk(clk),
        .rst(rst),
        .clr(state == IDLE),
        .en (accept),
        .sym(in_sym),
        .s1 (s1),
        .s2 (s2)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? COLLECT : IDLE;
            COLLECT: state_nx = (accept && idx == 4'(N - 1)) ? CALC : COLLECT;
            CALC:    state_nx = OUTPUT;
            OUTPUT:  state_nx = (idx == 4'(K - 1)) ? IDLE : OUTPUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) sym_buf[idx] <= in_sym;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            idx               <= 4'h0;
            fix_e             <= 4'h0;
            fix_p             <= 4'h0;
            corr_q            <= 1'b0;
            uncorr_q          <= 1'b0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            corr_cnt          <= '0;
            uncorr_cnt        <= '0;
        end else begin
            state <= state_nx;
            if (accept) idx <= (idx == 4'(N - 1)) ? 4'h0 : idx + 4'h1;
            else if (state == OUTPUT) idx <= (idx == 4'(K - 1)) ? 4'h0 : idx + 4'h1;
            // X = alpha^d locates the error at degree d, i.e. buffer slot 14-d
            if (state == CALC) begin
                corr_q   <= s1 != 4'h0 && s2 != 4'h0;
                uncorr_q <= (s1 != 4'h0) != (s2 != 4'h0);
                fix_e    <= gf_mul(gf_mul(s1, s1), GF_INV[s2]);
                fix_p    <= 4'(N - 1) - GF_LOG[calc_x];
            end
            // commit one cycle early so flags and counters are already valid alongside cw_done
            if (state == OUTPUT && idx == 4'(K - 2)) begin
                err_corrected     <= corr_q;
                err_uncorrectable <= uncorr_q;
                if (corr_q && corr_cnt != {CNT_W{1'b1}}) corr_cnt <= corr_cnt + CNT_W'(1);
                if (uncorr_q && uncorr_cnt != {CNT_W{1'b1}}) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rs15_13_gf16_decoder.sv
// tb_rs15_13_gf16_decoder: randomized checks of the RS(15,13) decoder against a log/exp-table GF model
module tb_rs15_13_gf16_decoder;
    typedef logic [3:0] cw_t [15];
    typedef logic [3:0] dat_t [13];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] in_sym = 4'h0;
    logic in_valid = 1'b0;
    logic rdy0, ov0, ol0, cd0, ec0, eu0;
    logic [3:0] osym0;
    logic [15:0] cc0, uc0;
    logic rdy1, ov1, ol1, cd1, ec1, eu1;
    logic [3:0] osym1;
    logic [1:0] cc1, uc1;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [3:0] gexp [15];
    int glog [16];
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    int done_cnt = 0, acc_cnt = 0, nr_cnt = 0, acc_cyc = 0, first_ov_cyc = -1, ol_pos = 0;
    logic fl_c0 = 1'b0, fl_u0 = 1'b0, fl_c1 = 1'b0, fl_u1 = 1'b0;
    int exp_corr = 0, exp_uncorr = 0;

    rs15_13_gf16_decoder #(.CORRECT_EN(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_sym(in_sym), .in_valid(in_valid), .in_ready(rdy0),
        .out_sym(osym0), .out_valid(ov0), .out_last(ol0), .cw_done(cd0),
        .err_corrected(ec0), .err_uncorrectable(eu0), .corr_cnt(cc0), .uncorr_cnt(uc0)
    );

    // raw-output variant with narrow counters so saturation is reachable
    rs15_13_gf16_decoder #(.CORRECT_EN(1'b0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_sym(in_sym), .in_valid(in_valid), .in_ready(rdy1),
        .out_sym(osym1), .out_valid(ov1), .out_last(ol1), .cw_done(cd1),
        .err_corrected(ec1), .err_uncorrectable(eu1), .corr_cnt(cc1), .uncorr_cnt(uc1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && rdy0) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
        if (!rdy0) nr_cnt <= nr_cnt + 1;
        if (ov0) begin
            q0.push_back(osym0);
            if (first_ov_cyc < 0) first_ov_cyc <= cyc;
        end
        if (ov1) q1.push_back(osym1);
        if (ol0) ol_pos <= q0.size();
        if (cd0) begin
            done_cnt <= done_cnt + 1;
            fl_c0 <= ec0;
            fl_u0 <= eu0;
        end
        if (cd1) begin
            fl_c1 <= ec1;
            fl_u1 <= eu1;
        end
    end

    function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
        return (a == 4'h0 || b == 4'h0) ? 4'h0 : gexp[(glog[a] + glog[b]) % 15];
    endfunction

    function automatic logic [3:0] gdiv(input logic [3:0] a, input logic [3:0] b);
        return (a == 4'h0) ? 4'h0 : gexp[(glog[a] - glog[b] + 15) % 15];
    endfunction

    task automatic model(input cw_t r, output dat_t oc, output dat_t orw, output logic c, output logic u);
        logic [3:0] s1, s2, e;
        int p;
        s1 = 4'h0; s2 = 4'h0; e = 4'h0; p = -1;
        for (int i = 0; i < 15; i++) begin
            s1 ^= gm(r[i], gexp[(14 - i) % 15]);
            s2 ^= gm(r[i], gexp[(2 * (14 - i)) % 15]);
        end
        c = s1 != 4'h0 && s2 != 4'h0;
        u = (s1 != 4'h0) != (s2 != 4'h0);
        if (c)
            for (int d = 0; d < 15; d++)
                if (gm(s1, gexp[d]) == s2) begin
                    p = 14 - d;
                    e = gdiv(s1, gexp[d]);
                end
        for (int k = 0; k < 13; k++) begin
            orw[k] = r[k];
            oc[k] = (k == p) ? r[k] ^ e : r[k];
        end
    endtask

    task automatic encode(inout cw_t r);
        logic [3:0] d1, d2;
        d1 = 4'h0; d2 = 4'h0;
        for (int i = 0; i < 13; i++) begin
            d1 ^= gm(r[i], gexp[(14 - i) % 15]);
            d2 ^= gm(r[i], gexp[(2 * (14 - i)) % 15]);
        end
        r[13] = gdiv(d1 ^ d2, gexp[1] ^ gexp[2]);
        r[14] = d1 ^ gm(r[13], gexp[1]);
    endtask

    task automatic drive_cw(input cw_t r, input int n, input int gap, input bit hold);
        int t;
        for (int i = 0; i < n; i++) begin
            in_sym = r[i];
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!rdy0 && t < 100) begin
                t++;
                @(negedge clk);
            end
            if (t >= 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL drive_timeout: in_ready stayed 0 for symbol %0d, required 1", i);
            end
            @(posedge clk);
            #1;
            if (gap > 0 && i < n - 1) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start, t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < 200) begin
            @(posedge clk);
            t++;
        end
        n_chk++;
        if (done_cnt == start) begin
            n_fail++;
            $display("FAIL %s done_timeout: no cw_done within %0d cycles", name, t);
        end
        #1;
    endtask

    task automatic run_cw(input string name, input cw_t r, input int gap, input bit hold);
        dat_t oc, orw;
        logic c, u;
        int sat;
        q0.delete();
        q1.delete();
        acc_cnt = 0;
        nr_cnt = 0;
        ol_pos = 0;
        first_ov_cyc = -1;
        model(r, oc, orw, c, u);
        drive_cw(r, 15, gap, hold);
        wait_done(name);
        n_chk += 2;
        if (q0.size() != 13) begin n_fail++; $display("FAIL %s count0: got %0d outputs, required 13", name, q0.size()); end
        if (q1.size() != 13) begin n_fail++; $display("FAIL %s count1: got %0d outputs, required 13", name, q1.size()); end
        for (int k = 0; k < 13; k++) begin
            n_chk += 2;
            if (k >= q0.size() || q0[k] !== oc[k]) begin
                n_fail++;
                $display("FAIL %s sym%0d corrected: got %h, required %h", name, k, (k < q0.size()) ? q0[k] : 4'hx, oc[k]);
            end
            if (k >= q1.size() || q1[k] !== orw[k]) begin
                n_fail++;
                $display("FAIL %s sym%0d raw: got %h, required %h", name, k, (k < q1.size()) ? q1[k] : 4'hx, orw[k]);
            end
        end
        exp_corr += int'(c);
        exp_uncorr += int'(u);
        sat = (exp_corr > 3) ? 3 : exp_corr;
        n_chk += 12;
        if (fl_c0 !== c) begin n_fail++; $display("FAIL %s err_corrected: got %b, required %b", name, fl_c0, c); end
        if (fl_u0 !== u) begin n_fail++; $display("FAIL %s err_uncorrectable: got %b, required %b", name, fl_u0, u); end
        if (fl_c1 !== c) begin n_fail++; $display("FAIL %s err_corrected_raw: got %b, required %b", name, fl_c1, c); end
        if (fl_u1 !== u) begin n_fail++; $display("FAIL %s err_uncorrectable_raw: got %b, required %b", name, fl_u1, u); end
        if (cc0 !== 16'(exp_corr)) begin n_fail++; $display("FAIL %s corr_cnt: got %0d, required %0d", name, cc0, exp_corr); end
        if (uc0 !== 16'(exp_uncorr)) begin n_fail++; $display("FAIL %s uncorr_cnt: got %0d, required %0d", name, uc0, exp_uncorr); end
        if (cc1 !== 2'(sat)) begin n_fail++; $display("FAIL %s corr_cnt_sat: got %0d, required %0d", name, cc1, sat); end
        sat = (exp_uncorr > 3) ? 3 : exp_uncorr;
        if (uc1 !== 2'(sat)) begin n_fail++; $display("FAIL %s uncorr_cnt_sat: got %0d, required %0d", name, uc1, sat); end
        if (first_ov_cyc - acc_cyc != 2) begin n_fail++; $display("FAIL %s latency: got %0d cycles, required 2", name, first_ov_cyc - acc_cyc); end
        if (ol_pos != 13) begin n_fail++; $display("FAIL %s out_last_pos: got %0d, required 13", name, ol_pos); end
        if (acc_cnt != 15) begin n_fail++; $display("FAIL %s accepted: got %0d, required 15", name, acc_cnt); end
        if (nr_cnt != 14) begin n_fail++; $display("FAIL %s not_ready_cycles: got %0d, required 14", name, nr_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk += 8;
        if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b, required 1", rdy0); end
        if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, required 0", ov0); end
        if (osym0 !== 4'h0) begin n_fail++; $display("FAIL reset out_sym: got %h, required 0", osym0); end
        if (ol0 !== 1'b0 || cd0 !== 1'b0) begin n_fail++; $display("FAIL reset last/done: got %b%b, required 00", ol0, cd0); end
        if (ec0 !== 1'b0) begin n_fail++; $display("FAIL reset err_corrected: got %b, required 0", ec0); end
        if (eu0 !== 1'b0) begin n_fail++; $display("FAIL reset err_uncorrectable: got %b, required 0", eu0); end
        if (cc0 !== 16'h0) begin n_fail++; $display("FAIL reset corr_cnt: got %0d, required 0", cc0); end
        if (uc0 !== 16'h0) begin n_fail++; $display("FAIL reset uncorr_cnt: got %0d, required 0", uc0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        cw_t r;
        for (int i = 0; i < 15; i++) r[i] = 4'h0;
        run_cw("zero", r, 0, 1'b0);
    endtask

    task automatic test_single_error();
        cw_t r;
        for (int i = 0; i < 15; i++) r[i] = 4'h0;
        r[0] = 4'h5;
        run_cw("single_err", r, 0, 1'b0);
        n_chk += 4;
        if (q0.size() < 1 || q0[0] !== 4'h0) begin n_fail++; $display("FAIL single_err fixed_sym0: got %h, required 0", (q0.size() > 0) ? q0[0] : 4'hx); end
        if (q1.size() < 1 || q1[0] !== 4'h5) begin n_fail++; $display("FAIL single_err raw_sym0: got %h, required 5", (q1.size() > 0) ? q1[0] : 4'hx); end
        if (fl_c0 !== 1'b1) begin n_fail++; $display("FAIL single_err flag: got %b, required 1", fl_c0); end
        if (fl_c1 !== 1'b1) begin n_fail++; $display("FAIL single_err flag_raw: got %b, required 1", fl_c1); end
    endtask

    task automatic test_uncorrectable();
        cw_t r;
        for (int i = 0; i < 15; i++) r[i] = 4'h0;
        r[13] = 4'h9;
        r[14] = 4'h1;
        run_cw("uncorr", r, 0, 1'b0);
        n_chk += 2;
        if (fl_u0 !== 1'b1 || fl_c0 !== 1'b0) begin n_fail++; $display("FAIL uncorr flags: got c=%b u=%b, required c=0 u=1", fl_c0, fl_u0); end
        if (ec0 !== 1'b0 || eu0 !== 1'b1) begin n_fail++; $display("FAIL uncorr held_flags: got c=%b u=%b, required c=0 u=1", ec0, eu0); end
    endtask

    task automatic test_gaps();
        cw_t a, b;
        for (int i = 0; i < 13; i++) begin
            a[i] = 4'($urandom_range(0, 15));
            b[i] = 4'($urandom_range(0, 15));
        end
        encode(a);
        encode(b);
        a[$urandom_range(0, 14)] ^= 4'($urandom_range(1, 15));
        run_cw("gaps_hold", a, 1, 1'b1);
        run_cw("after_gaps", b, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cw_t r;
        for (int i = 0; i < 15; i++) r[i] = 4'h0;
        r[2] = 4'h7;
        drive_cw(r, 7, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_corr = 0;
        exp_uncorr = 0;
        q0.delete();
        repeat (25) @(posedge clk);
        #1;
        n_chk += 4;
        if (q0.size() != 0) begin n_fail++; $display("FAIL reset_mid outputs: got %0d, required 0", q0.size()); end
        if (cc0 !== 16'h0 || uc0 !== 16'h0) begin n_fail++; $display("FAIL reset_mid counters: got %0d/%0d, required 0/0", cc0, uc0); end
        if (ec0 !== 1'b0 || eu0 !== 1'b0) begin n_fail++; $display("FAIL reset_mid flags: got %b%b, required 00", ec0, eu0); end
        if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_mid in_ready: got %b, required 1", rdy0); end
        r[2] = 4'h0;
        run_cw("post_reset", r, 0, 1'b0);
    endtask

    task automatic test_random();
        cw_t r;
        int nerr;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 13; i++) r[i] = 4'($urandom_range(0, 15));
            encode(r);
            nerr = $urandom_range(0, 2);
            for (int e = 0; e < nerr; e++) r[$urandom_range(0, 14)] ^= 4'($urandom_range(1, 15));
            run_cw($sformatf("random%0d", n), r, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] v;
        gexp[0] = 4'h1;
        glog[0] = 0;
        glog[1] = 0;
        for (int i = 1; i < 15; i++) begin
            v = {gexp[i-1], 1'b0};
            if (v[4]) v = v ^ 5'h13;
            gexp[i] = v[3:0];
            glog[v[3:0]] = i;
        end
        test_reset();
        test_zero();
        test_single_error();
        test_uncorrectable();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
